// File: rtl/noc_vc_input_unit.sv
// noc_vc_input_unit
// -----------------
// Input unit of a mesh router with per-virtual-channel FIFOs and an output
// arbiter. Upstream flits are queued into the FIFO of their VC. A
// round-robin arbiter picks a non-empty VC and presents its head flit
// downstream. Once a head flit has been sent, the arbiter stays on that VC
// until the matching tail has been sent. An XY route (one-hot output port)
// is computed from head and single flits. The head's route is remembered per
// VC so that body and tail flits follow it.
//
// Flit type field (top two bits): 01 head, 00 body, 10 tail, 11 single.
// Head destination: x in [X_W-1:0], y in [X_W+Y_W-1:X_W].
// Route bits: 0 local, 1 north, 2 east, 3 south, 4 west.
//
// Ports
//   clk              single clock
//   rst_             asynchronous active-low reset
//   my_xpos/my_ypos  this router's coordinates (quasi-static)
//   idata/ivalid/ivch  upstream flit, valid and target VC
//   oack[v]          one-cycle pulse after a flit is accepted on VC v
//   ordy[v]          VC v has at least one free slot
//   olck[v]          a packet is open on the input side of VC v
//   odata/ovalid/ovch/oport  presented flit, its VC and one-hot route
//   iready           downstream accepts; a transfer is ovalid && iready
module noc_vc_input_unit #(
  parameter int DATA_W = 35,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [X_W-1:0]    my_xpos,
  input  logic [Y_W-1:0]    my_ypos,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivalid,
  input  logic [VC_W-1:0]   ivch,
  output logic [NUM_VC-1:0] oack,
  output logic [NUM_VC-1:0] ordy,
  output logic [NUM_VC-1:0] olck,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VC_W-1:0]   ovch,
  output logic [4:0]        oport,
  input  logic              iready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [4:0] PORT_LOCAL = 5'b00001;
  localparam logic [4:0] PORT_NORTH = 5'b00010;
  localparam logic [4:0] PORT_EAST  = 5'b00100;
  localparam logic [4:0] PORT_SOUTH = 5'b01000;
  localparam logic [4:0] PORT_WEST  = 5'b10000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q    [NUM_VC][DEPTH];
  logic [DATA_W-1:0] mem_d    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]  count_q  [NUM_VC];
  logic [CNT_W-1:0]  count_d  [NUM_VC];
  logic [4:0]        route_q  [NUM_VC];
  logic [4:0]        route_d  [NUM_VC];
  logic [NUM_VC-1:0] oack_q, oack_d;
  logic [NUM_VC-1:0] olck_q, olck_d;

  // Arbiter state
  arb_state_e        state_q, state_d;
  logic [VC_W-1:0]   hold_vc_q, hold_vc_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              sel_lock_q, sel_lock_d;
  logic [VC_W-1:0]   sel_vc_q, sel_vc_d;

  // Combinational helpers
  logic              in_vc_ok;
  logic              accept;
  logic [1:0]        in_type;
  logic              pick_found;
  logic [VC_W-1:0]   pick_vc;
  logic [DATA_W-1:0] pick_flit;
  logic [1:0]        pick_type;
  logic [4:0]        pick_route;
  logic              xfer;

  // Dimension-order routing: resolve x first, then y, else local.
  function automatic logic [4:0] xy_route(input logic [X_W-1:0] dx,
                                          input logic [Y_W-1:0] dy,
                                          input logic [X_W-1:0] mx,
                                          input logic [Y_W-1:0] my);
    logic [4:0] r;
    if (dx > mx)      r = PORT_EAST;
    else if (dx < mx) r = PORT_WEST;
    else if (dy > my) r = PORT_NORTH;
    else if (dy < my) r = PORT_SOUTH;
    else              r = PORT_LOCAL;
    return r;
  endfunction

  function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
    return VC_W'((int'(v) + 1) % NUM_VC);
  endfunction

  // A VC has room whenever its registered count is below the depth. The
  // count is cleared asynchronously, so ordy is all ones during reset.
  always_comb begin
    ordy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      ordy[v] = (count_q[v] < FULL_CNT);
    end
  end

  // A flit is accepted only when its VC exists and had room at the start
  // of the cycle. A pop in the same cycle does not make room early.
  always_comb begin
    in_vc_ok = (int'(ivch) < NUM_VC);
    accept   = ivalid && in_vc_ok && ordy[ivch];
    in_type  = idata[DATA_W-1:DATA_W-2];
  end

  // Output selection. In HOLD only the owning VC may be shown. Once a flit
  // has been shown without being taken, sel_lock pins the same VC. This keeps
  // a newly filled VC from displacing it before the transfer.
  always_comb begin
    int          idx;
    logic [VC_W-1:0] idx_vc;
    pick_found = 1'b0;
    pick_vc    = '0;
    idx        = 0;
    idx_vc     = '0;
    if (state_q == ST_HOLD) begin
      pick_vc    = hold_vc_q;
      pick_found = (count_q[hold_vc_q] != '0);
    end else if (sel_lock_q) begin
      pick_vc    = sel_vc_q;
      pick_found = (count_q[sel_vc_q] != '0);
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        idx    = (int'(rr_ptr_q) + i) % NUM_VC;
        idx_vc = VC_W'(idx);
        if (!pick_found && (count_q[idx_vc] != '0)) begin
          pick_found = 1'b1;
          pick_vc    = idx_vc;
        end
      end
    end
  end

  // Presented flit and its route. Head and single flits carry their own
  // destination. Body and tail flits reuse the route stored by their head.
  always_comb begin
    pick_flit = mem_q[pick_vc][rd_ptr_q[pick_vc]];
    pick_type = pick_flit[DATA_W-1:DATA_W-2];
    if ((pick_type == FT_HEAD) || (pick_type == FT_SINGLE)) begin
      pick_route = xy_route(pick_flit[X_W-1:0], pick_flit[X_W+Y_W-1:X_W],
                            my_xpos, my_ypos);
    end else begin
      pick_route = route_q[pick_vc];
    end
    xfer   = pick_found && iready;
    ovalid = pick_found;
    odata  = pick_found ? pick_flit  : '0;
    ovch   = pick_found ? pick_vc    : '0;
    oport  = pick_found ? pick_route : '0;
  end

  // Arbiter next state. A head sent from IDLE opens HOLD on its VC. The
  // matching tail closes it. The round-robin pointer moves past the VC
  // that was just served.
  always_comb begin
    state_d    = state_q;
    hold_vc_d  = hold_vc_q;
    rr_ptr_d   = rr_ptr_q;
    sel_lock_d = pick_found && !iready;
    sel_vc_d   = pick_vc;
    if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          rr_ptr_d = next_vc(pick_vc);
          if (pick_type == FT_HEAD) begin
            state_d   = ST_HOLD;
            hold_vc_d = pick_vc;
          end
        end
        ST_HOLD: begin
          if (pick_type == FT_TAIL) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_vc(pick_vc);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FIFO pushes and pops, acknowledge pulses, input-side packet locks and
  // per-VC route memory.
  always_comb begin
    logic push_v;
    logic pop_v;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    route_d  = route_q;
    olck_d   = olck_q;
    oack_d   = '0;
    push_v   = 1'b0;
    pop_v    = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_v = accept && (int'(ivch) == v);
      pop_v  = xfer && (int'(pick_vc) == v);
      if (push_v) begin
        mem_d[v][wr_ptr_q[v]] = idata;
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
        oack_d[v]   = 1'b1;
        if (in_type == FT_HEAD) begin
          olck_d[v] = 1'b1;
        end else if (in_type == FT_TAIL) begin
          olck_d[v] = 1'b0;
        end
      end
      if (pop_v) begin
        rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
        if ((state_q == ST_IDLE) && (pick_type == FT_HEAD)) begin
          route_d[v] = pick_route;
        end
      end
      case ({push_v, pop_v})
        2'b10:   count_d[v] = count_q[v] + CNT_W'(1);
        2'b01:   count_d[v] = count_q[v] - CNT_W'(1);
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NUM_VC; v++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[v][d] <= '0;
        end
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        route_q[v]  <= '0;
      end
      oack_q <= '0;
      olck_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      route_q  <= route_d;
      oack_q   <= oack_d;
      olck_q   <= olck_d;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      hold_vc_q  <= '0;
      rr_ptr_q   <= '0;
      sel_lock_q <= 1'b0;
      sel_vc_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_vc_q  <= hold_vc_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_lock_q <= sel_lock_d;
      sel_vc_q   <= sel_vc_d;
    end
  end

  assign oack = oack_q;
  assign olck = olck_q;

endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Directed testbench for noc_vc_input_unit with default parameters
// (35-bit flits, 2 VCs, depth 4, 2-bit coordinates, router at (1,1)).
module tb_noc_vc_input_unit;

  localparam int DATA_W = 35;
  localparam int VC_W   = 1;

  logic              clk = 1'b0;
  logic              rst_;
  logic [1:0]        my_xpos;
  logic [1:0]        my_ypos;
  logic [DATA_W-1:0] idata;
  logic              ivalid;
  logic [VC_W-1:0]   ivch;
  logic [1:0]        oack;
  logic [1:0]        ordy;
  logic [1:0]        olck;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VC_W-1:0]   ovch;
  logic [4:0]        oport;
  logic              iready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_vc_input_unit #(
    .DATA_W(35), .NUM_VC(2), .DEPTH(4), .X_W(2), .Y_W(2)
  ) dut (
    .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .oack(oack), .ordy(ordy), .olck(olck),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .oport(oport),
    .iready(iready)
  );

  function automatic logic [DATA_W-1:0] mk_flit(input logic [1:0] t,
                                                input logic [1:0] dx,
                                                input logic [1:0] dy,
                                                input logic [28:0] pay);
    return {t, pay, dy, dx};
  endfunction

  // Drive one upstream slot across a clock edge, then sample 1 time unit
  // after the edge with the inputs idle again.
  task automatic applyStimulus(input logic v, input logic [VC_W-1:0] vc,
                               input logic [DATA_W-1:0] d);
    ivalid = v;
    ivch   = vc;
    idata  = d;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    ivch   = '0;
    idata  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DATA_W-1:0] f_a, f_b, f_c;
  logic [DATA_W-1:0] s0a, s0b, s1a, s1b;
  logic [DATA_W-1:0] r1, r2, r3;
  logic [DATA_W-1:0] q1, q2, q3, q4, q5, q6;
  logic [DATA_W-1:0] fh, fs, fb, ft;
  logic [DATA_W-1:0] h2, b2, p1;

  initial begin
    $display("[TB] start");
    rst_    = 1'b0;
    ivalid  = 1'b0;
    ivch    = '0;
    idata   = '0;
    iready  = 1'b0;
    my_xpos = 2'd1;
    my_ypos = 2'd1;

    f_a = mk_flit(2'b11, 2'd3, 2'd1, 29'h0AA);
    f_b = mk_flit(2'b11, 2'd1, 2'd2, 29'h0BB);
    f_c = mk_flit(2'b11, 2'd0, 2'd0, 29'h0CC);
    s0a = mk_flit(2'b11, 2'd1, 2'd1, 29'h001);
    s0b = mk_flit(2'b11, 2'd1, 2'd1, 29'h002);
    s1a = mk_flit(2'b11, 2'd1, 2'd1, 29'h003);
    s1b = mk_flit(2'b11, 2'd1, 2'd1, 29'h004);
    r1  = mk_flit(2'b11, 2'd1, 2'd0, 29'h011);
    r2  = mk_flit(2'b11, 2'd0, 2'd1, 29'h012);
    r3  = mk_flit(2'b11, 2'd1, 2'd1, 29'h013);
    q1  = mk_flit(2'b11, 2'd1, 2'd1, 29'h021);
    q2  = mk_flit(2'b11, 2'd1, 2'd1, 29'h022);
    q3  = mk_flit(2'b11, 2'd1, 2'd1, 29'h023);
    q4  = mk_flit(2'b11, 2'd1, 2'd1, 29'h024);
    q5  = mk_flit(2'b11, 2'd1, 2'd1, 29'h025);
    q6  = mk_flit(2'b11, 2'd1, 2'd1, 29'h026);
    fh  = mk_flit(2'b01, 2'd3, 2'd1, 29'h031);
    fs  = mk_flit(2'b11, 2'd1, 2'd2, 29'h032);
    fb  = mk_flit(2'b00, 2'd0, 2'd0, 29'h033);
    ft  = mk_flit(2'b10, 2'd0, 2'd0, 29'h034);
    h2  = mk_flit(2'b01, 2'd3, 2'd1, 29'h041);
    b2  = mk_flit(2'b00, 2'd0, 2'd0, 29'h042);
    p1  = mk_flit(2'b11, 2'd1, 2'd0, 29'h051);

    // Reset values
    #3;
    checkOutput("rst_ordy",   64'(ordy),   64'(2'b11));
    checkOutput("rst_oack",   64'(oack),   64'(2'b00));
    checkOutput("rst_olck",   64'(olck),   64'(2'b00));
    checkOutput("rst_ovalid", 64'(ovalid), 64'(1'b0));
    checkOutput("rst_odata",  64'(odata),  64'(0));
    checkOutput("rst_oport",  64'(oport),  64'(0));
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("post_rst_ordy", 64'(ordy), 64'(2'b11));

    // Single flit on VC0 towards (3,1): east
    applyStimulus(1'b1, 1'b0, f_a);
    checkOutput("s1_oack", 64'(oack), 64'(2'b01));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("s1_oack_pulse", 64'(oack),   64'(2'b00));
    checkOutput("s1_ovalid",     64'(ovalid), 64'(1'b1));
    checkOutput("s1_oport",      64'(oport),  64'(5'b00100));
    checkOutput("s1_ovch",       64'(ovch),   64'(1'b0));
    checkOutput("s1_odata",      64'(odata),  64'(f_a));
    iready = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("s1_drained_ovalid", 64'(ovalid), 64'(1'b0));
    checkOutput("s1_drained_odata",  64'(odata),  64'(0));
    checkOutput("s1_drained_oport",  64'(oport),  64'(0));

    // Presented flit stays put under backpressure while another VC fills
    iready = 1'b0;
    applyStimulus(1'b1, 1'b0, f_b);
    applyStimulus(1'b1, 1'b1, f_c);
    checkOutput("stall_ovch",  64'(ovch),  64'(1'b0));
    checkOutput("stall_odata", 64'(odata), 64'(f_b));
    checkOutput("stall_oport", 64'(oport), 64'(5'b00010));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall2_odata", 64'(odata), 64'(f_b));
    iready = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall_next_ovch",  64'(ovch),  64'(1'b1));
    checkOutput("stall_next_odata", 64'(odata), 64'(f_c));
    checkOutput("stall_next_oport", 64'(oport), 64'(5'b10000));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall_empty", 64'(ovalid), 64'(1'b0));

    // Both VCs hold single flits: service alternates 0,1,0,1
    iready = 1'b0;
    applyStimulus(1'b1, 1'b0, s0a);
    applyStimulus(1'b1, 1'b1, s1a);
    applyStimulus(1'b1, 1'b0, s0b);
    applyStimulus(1'b1, 1'b1, s1b);
    checkOutput("alt0_ovch",  64'(ovch),  64'(1'b0));
    checkOutput("alt0_odata", 64'(odata), 64'(s0a));
    checkOutput("alt0_oport", 64'(oport), 64'(5'b00001));
    iready = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("alt1_ovch",  64'(ovch),  64'(1'b1));
    checkOutput("alt1_odata", 64'(odata), 64'(s1a));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("alt2_ovch",  64'(ovch),  64'(1'b0));
    checkOutput("alt2_odata", 64'(odata), 64'(s0b));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("alt3_ovch",  64'(ovch),  64'(1'b1));
    checkOutput("alt3_odata", 64'(odata), 64'(s1b));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("alt_empty", 64'(ovalid), 64'(1'b0));

    // Route checks from (1,1): (1,0) south, (0,1) west, (1,1) local
    applyStimulus(1'b1, 1'b0, r1);
    checkOutput("route_south", 64'(oport), 64'(5'b01000));
    applyStimulus(1'b1, 1'b0, r2);
    checkOutput("route_west", 64'(oport), 64'(5'b10000));
    applyStimulus(1'b1, 1'b0, r3);
    checkOutput("route_local", 64'(oport), 64'(5'b00001));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("route_empty", 64'(ovalid), 64'(1'b0));

    // Fill VC1 to depth, overflow is dropped even while a pop happens
    iready = 1'b0;
    applyStimulus(1'b1, 1'b1, q1);
    checkOutput("full_ack1", 64'(oack), 64'(2'b10));
    applyStimulus(1'b1, 1'b1, q2);
    checkOutput("full_ack2", 64'(oack), 64'(2'b10));
    applyStimulus(1'b1, 1'b1, q3);
    checkOutput("full_ack3",  64'(oack), 64'(2'b10));
    checkOutput("full_ordy3", 64'(ordy), 64'(2'b11));
    applyStimulus(1'b1, 1'b1, q4);
    checkOutput("full_ack4",  64'(oack), 64'(2'b10));
    checkOutput("full_ordy4", 64'(ordy), 64'(2'b01));
    applyStimulus(1'b1, 1'b1, q5);
    checkOutput("full_ack5",  64'(oack), 64'(2'b00));
    checkOutput("full_ordy5", 64'(ordy), 64'(2'b01));
    checkOutput("full_head",  64'(odata), 64'(q1));
    iready = 1'b1;
    applyStimulus(1'b1, 1'b1, q6);
    checkOutput("full_ack6",  64'(oack), 64'(2'b00));
    checkOutput("full_ordy6", 64'(ordy), 64'(2'b11));
    checkOutput("full_d2",    64'(odata), 64'(q2));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("full_d3", 64'(odata), 64'(q3));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("full_d4", 64'(odata), 64'(q4));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("full_empty", 64'(ovalid), 64'(1'b0));

    // Head/body/tail on VC0 interleaved with a single flit on VC1
    applyStimulus(1'b1, 1'b0, fh);
    checkOutput("pkt_h_olck",  64'(olck),  64'(2'b01));
    checkOutput("pkt_h_odata", 64'(odata), 64'(fh));
    checkOutput("pkt_h_oport", 64'(oport), 64'(5'b00100));
    applyStimulus(1'b1, 1'b1, fs);
    checkOutput("pkt_hold_ovalid", 64'(ovalid), 64'(1'b0));
    checkOutput("pkt_s_olck",      64'(olck),   64'(2'b01));
    applyStimulus(1'b1, 1'b0, fb);
    checkOutput("pkt_b_odata", 64'(odata), 64'(fb));
    checkOutput("pkt_b_ovch",  64'(ovch),  64'(1'b0));
    checkOutput("pkt_b_oport", 64'(oport), 64'(5'b00100));
    checkOutput("pkt_b_olck",  64'(olck),  64'(2'b01));
    applyStimulus(1'b1, 1'b0, ft);
    checkOutput("pkt_t_odata", 64'(odata), 64'(ft));
    checkOutput("pkt_t_oport", 64'(oport), 64'(5'b00100));
    checkOutput("pkt_t_olck",  64'(olck),  64'(2'b00));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("pkt_s_odata", 64'(odata), 64'(fs));
    checkOutput("pkt_s_ovch",  64'(ovch),  64'(1'b1));
    checkOutput("pkt_s_oport", 64'(oport), 64'(5'b00010));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("pkt_empty", 64'(ovalid), 64'(1'b0));

    // Reset in the middle of a packet held on VC0
    applyStimulus(1'b1, 1'b0, h2);
    applyStimulus(1'b1, 1'b0, b2);
    checkOutput("mid_ovalid", 64'(ovalid), 64'(1'b1));
    checkOutput("mid_olck",   64'(olck),   64'(2'b01));
    iready = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    checkOutput("mrst_ovalid", 64'(ovalid), 64'(1'b0));
    checkOutput("mrst_olck",   64'(olck),   64'(2'b00));
    checkOutput("mrst_ordy",   64'(ordy),   64'(2'b11));
    checkOutput("mrst_oack",   64'(oack),   64'(2'b00));
    checkOutput("mrst_odata",  64'(odata),  64'(0));
    @(posedge clk);
    #1;
    rst_   = 1'b1;
    iready = 1'b1;
    applyStimulus(1'b1, 1'b1, p1);
    checkOutput("after_oack",   64'(oack),   64'(2'b10));
    checkOutput("after_ovalid", 64'(ovalid), 64'(1'b1));
    checkOutput("after_ovch",   64'(ovch),   64'(1'b1));
    checkOutput("after_oport",  64'(oport),  64'(5'b01000));
    checkOutput("after_odata",  64'(odata),  64'(p1));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("after_empty", 64'(ovalid), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
